// File: rtl/fp_mult_out_fifo.sv
// -----------------------------------------------------------------------------
// fp_mult_out_fifo
//
// Output buffer for the floating-point multiplier. Each entry holds the 32-bit
// IEEE-754 single-precision product plus the multiplier status flags
// {nan, exp_overflow, zero}. Reads are first-word fall-through: the head entry
// is always visible on out_res/out_flags while out_valid is high. There is no
// combinational path from in_* to out_*; a pushed entry becomes visible one
// clock after the push edge.
//
// Besides buffering, the block keeps two status views of everything accepted:
//   - sticky_flags : OR of the flags of all pushed entries since the last
//                    clr_sticky (a push in the clearing cycle still lands)
//   - nan_cnt      : saturating count of pushed NaN entries (clr_sticky does
//                    not touch it; only reset clears it)
//
// Parameters
//   DEPTH           entry count, power of two, >= 2
//
// Ports
//   clk             single clock, rising edge
//   rst             asynchronous, active-high reset
//   in_valid        multiplier result present
//   in_ready        FIFO can accept an entry (count != DEPTH)
//   in_res          32-bit product
//   in_exp_overflow multiplier overflow flag
//   in_nan          multiplier NaN flag
//   in_zero         multiplier zero flag
//   out_valid       head entry present (count != 0)
//   out_ready       consumer takes the head entry
//   out_res         head entry product
//   out_flags       head entry flags {nan, exp_overflow, zero}
//   count           occupied entries
//   clr_sticky      clears sticky_flags
//   sticky_flags    accumulated {nan, exp_overflow, zero}
//   nan_cnt         saturating count of accepted NaN entries
// -----------------------------------------------------------------------------
module fp_mult_out_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_res,
    input  logic                       in_exp_overflow,
    input  logic                       in_nan,
    input  logic                       in_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_res,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       clr_sticky,
    output logic [2:0]                 sticky_flags,
    output logic [7:0]                 nan_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 35;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    NAN_MAX  = 8'd255;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [2:0]    sticky_q;
    logic [7:0]    nan_cnt_q;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic          push;
    logic          pop;
    logic [2:0]    in_flags;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;

    // Ready/valid come only from the registered count, so a pop in the same
    // cycle never opens a slot for a push into a full buffer.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign in_flags = {in_nan, in_exp_overflow, in_zero};
    assign in_entry = {in_flags, in_res};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic [2:0]    sticky_nxt;
    logic [7:0]    nan_cnt_nxt;

    // DEPTH is a power of two, so the natural PW-bit rollover is the
    // modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (push) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
        end
    end

    always_comb begin
        count_nxt = count_q;
        unique case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Clear first, then OR in the current push so a same-cycle flag survives.
    always_comb begin
        sticky_nxt = clr_sticky ? 3'b000 : sticky_q;
        if (push) begin
            sticky_nxt = sticky_nxt | in_flags;
        end
    end

    always_comb begin
        nan_cnt_nxt = nan_cnt_q;
        if (push && in_nan && (nan_cnt_q != NAN_MAX)) begin
            nan_cnt_nxt = nan_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            sticky_q  <= 3'b000;
            nan_cnt_q <= 8'd0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count_q   <= count_nxt;
            sticky_q  <= sticky_nxt;
            nan_cnt_q <= nan_cnt_nxt;
        end
    end

    // Storage is not reset; stale contents are unreachable because the
    // pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head_entry   = mem[rd_ptr];
    assign out_res      = head_entry[31:0];
    assign out_flags    = head_entry[34:32];
    assign count        = count_q;
    assign sticky_flags = sticky_q;
    assign nan_cnt      = nan_cnt_q;

endmodule

// File: tb/tb_fp_mult_out_fifo.sv
module tb_fp_mult_out_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_res;
    logic          in_exp_overflow;
    logic          in_nan;
    logic          in_zero;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_res;
    logic [2:0]    out_flags;
    logic [CW-1:0] count;
    logic          clr_sticky;
    logic [2:0]    sticky_flags;
    logic [7:0]    nan_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of {flags, result} entries plus status values.
    logic [34:0] mq[$];
    logic [2:0]  m_sticky;
    int          m_nan;

    always #5 clk = ~clk;

    fp_mult_out_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_res         (in_res),
        .in_exp_overflow(in_exp_overflow),
        .in_nan         (in_nan),
        .in_zero        (in_zero),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_res        (out_res),
        .out_flags      (out_flags),
        .count          (count),
        .clr_sticky     (clr_sticky),
        .sticky_flags   (sticky_flags),
        .nan_cnt        (nan_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [34:0] head;
        chk({tag, ".count"},     32'(count),        32'(mq.size()));
        chk({tag, ".out_valid"}, 32'(out_valid),    32'(mq.size() != 0));
        chk({tag, ".in_ready"},  32'(in_ready),     32'(mq.size() != DEPTH));
        chk({tag, ".sticky"},    32'(sticky_flags), 32'(m_sticky));
        chk({tag, ".nan_cnt"},   32'(nan_cnt),      32'(m_nan));
        if (mq.size() != 0) begin
            head = mq[0];
            chk({tag, ".out_res"},   out_res,         head[31:0]);
            chk({tag, ".out_flags"}, 32'(out_flags),  32'(head[34:32]));
        end
    endtask

    // Called at a negedge: drive, let one rising edge happen, update the
    // model, then check at the following negedge.
    task automatic step(input logic v, input logic [31:0] res, input logic [2:0] f,
                        input logic ordy, input logic clr, input string tag);
        bit do_push;
        bit do_pop;
        in_valid        = v;
        in_res          = res;
        in_nan          = f[2];
        in_exp_overflow = f[1];
        in_zero         = f[0];
        out_ready       = ordy;
        clr_sticky      = clr;
        do_push = v && (mq.size() != DEPTH);
        do_pop  = ordy && (mq.size() != 0);
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({f, res});
        if (clr) m_sticky = 3'b000;
        if (do_push) m_sticky = m_sticky | f;
        if (do_push && f[2] && m_nan < 255) m_nan++;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++)
            step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, "drain");
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  f;
        rst = 1'b1; in_valid = 0; in_res = 0; in_exp_overflow = 0; in_nan = 0;
        in_zero = 0; out_ready = 0; clr_sticky = 0;
        m_sticky = 3'b000; m_nan = 0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Single push, visible next cycle.
        step(1'b1, 32'h40C00000, 3'b000, 1'b0, 1'b0, "single");
        chk("single.res_const", out_res, 32'h40C00000);
        drain();

        // Fill to full, fifth push dropped, drain in order.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h3F800000 + 32'(i), 3'(i), 1'b0, 1'b0, "fill");
        chk("full.in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 32'hDEADBEEF, 3'b111, 1'b0, 1'b0, "drop5");
        chk("full.count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk("pop_order", out_res, 32'h3F800000 + 32'(i));
            step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, "pop");
        end
        chk("empty.out_valid", 32'(out_valid), 32'd0);

        // Steady push+pop across pointer wrap.
        step(1'b1, 32'h11111111, 3'b000, 1'b0, 1'b0, "pre1");
        step(1'b1, 32'h22222222, 3'b000, 1'b0, 1'b0, "pre2");
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'hA0000000 + 32'(i), 3'b000, 1'b1, 1'b0, "pushpop");
        chk("pushpop.count", 32'(count), 32'd2);
        drain();

        // Clear with a same-cycle push: the push wins.
        step(1'b0, 32'h0, 3'b000, 1'b0, 1'b1, "preclr");
        step(1'b1, 32'h7F800001, 3'b100, 1'b0, 1'b0, "nan_push");
        step(1'b1, 32'h7F800000, 3'b010, 1'b0, 1'b1, "clr_push");
        chk("clr_push.sticky_const", 32'(sticky_flags), 32'b010);
        chk("clr_push.nan_const", 32'(nan_cnt), 32'd1);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            f = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 3) != 0), r, f, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), "rand");
        end
        drain();

        // Asynchronous reset with three entries buffered.
        step(1'b1, 32'h0000000A, 3'b100, 1'b0, 1'b0, "r1");
        step(1'b1, 32'h0000000B, 3'b010, 1'b0, 1'b0, "r2");
        step(1'b1, 32'h0000000C, 3'b001, 1'b0, 1'b0, "r3");
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        mq.delete(); m_sticky = 3'b000; m_nan = 0;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.sticky", 32'(sticky_flags), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.nan_cnt", 32'(nan_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h12345678, 3'b001, 1'b0, 1'b0, "post_rst");
        chk("post_rst.head", out_res, 32'h12345678);
        drain();

        // NaN saturation while draining continuously.
        for (int i = 0; i < 300; i++)
            step(1'b1, 32'h7FC00000 | 32'(i), 3'b100, 1'b1, 1'b0, "nan_sat");
        chk("nan_sat.const", 32'(nan_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mult_out_fifo.md
FP_MULT_OUT_FIFO -- requirements
Module: fp_mult_out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; a power of two, 2 or more.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  multiplier result present.
REQ-005 SHALL have port in_ready  output  1  FIFO can accept an entry.
REQ-006 SHALL have port in_res  input  32  IEEE-754 single product from the multiplier.
REQ-007 SHALL have port in_exp_overflow  input  1  multiplier overflow flag.
REQ-008 SHALL have port in_nan  input  1  multiplier NaN flag.
REQ-009 SHALL have port in_zero  input  1  multiplier zero flag.
REQ-010 SHALL have port out_valid  output  1  head entry present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the head entry.
REQ-012 SHALL have port out_res  output  32  head entry result.
REQ-013 SHALL have port out_flags  output  3  head entry flags, {nan, exp_overflow, zero}.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.
REQ-015 SHALL have port clr_sticky  input  1  clears the sticky status bits.
REQ-016 SHALL have port sticky_flags  output  3  accumulated {nan, exp_overflow, zero} since the last clear.
REQ-017 SHALL have port nan_cnt  output  8  saturating count of accepted NaN entries.

Function
REQ-018 SHALL store 35-bit entries {in_nan, in_exp_overflow, in_zero, in_res} in a DEPTH-deep circular buffer.
REQ-019 SHALL push an entry when in_valid and in_ready are both 1 at the clock edge.
REQ-020 SHALL pop the head entry when out_valid and out_ready are both 1 at the clock edge.
REQ-021 SHALL drive in_ready = (count != DEPTH), combinationally from registered state only.
REQ-022 SHALL drive out_valid = (count != 0); out_res and out_flags SHALL show the head entry (first-word fall-through).
REQ-023 SHALL have a latency of 1 cycle: an entry pushed at edge N is visible on out_* after edge N; there is no combinational in->out bypass when empty.
REQ-024 SHALL, on simultaneous push and pop, advance both pointers and hold count unchanged.
REQ-025 SHALL not push when full, even if a pop occurs in the same cycle (in_ready = 0 when full).
REQ-026 SHALL wrap the read and write pointers modulo DEPTH.
REQ-027 SHALL leave out_res and out_flags as don't-care when out_valid = 0; the bench SHALL not check them then.
REQ-028 SHALL set each sticky_flags bit on a push whose corresponding input flag is 1.
REQ-029 SHALL clear sticky_flags to 0 on clr_sticky = 1, except that a same-cycle push setting a bit SHALL win for that bit.
REQ-030 SHALL increment nan_cnt on each push with in_nan = 1, saturating at 255.
REQ-031 SHALL not affect nan_cnt with clr_sticky.
REQ-032 SHALL ignore in_* when in_valid = 0 or in_ready = 0, and SHALL make no flag, counter or pointer update in that case.
REQ-033 SHALL not alter stored entries; payloads pass through bit-exact.

Reset
REQ-034 SHALL, while rst = 1 (asynchronously), force pointers and count to 0, sticky_flags to 0, nan_cnt to 0, out_valid to 0 and in_ready to 1.
REQ-035 SHALL discard all buffered entries when reset is asserted mid-operation; the first push after release SHALL appear as the head.
REQ-036 SHALL not require storage array contents to be reset.

Verification
REQ-037 SHALL pass: push 0x40C00000 flags 000, out_ready = 0 -> next cycle out_valid = 1, out_res = 0x40C00000, count = 1.
REQ-038 SHALL pass: push 4 entries with out_ready = 0 (DEPTH = 4) -> in_ready = 0, count = 4; a 5th in_valid is dropped; 4 pops return entries in order, then out_valid = 0.
REQ-039 SHALL pass: with count = 2, push and pop in the same cycle for 10 cycles -> count stays 2, order is preserved across pointer wrap.
REQ-040 SHALL pass: push 0x7F800001 flags 100, then assert clr_sticky together with a push of 0x7F800000 flags 010 -> sticky_flags = 010 and nan_cnt = 1.
REQ-041 SHALL pass: push 300 NaN entries while draining continuously -> nan_cnt = 255.
REQ-042 SHALL pass: assert rst between clock edges with count = 3 -> out_valid = 0, count = 0 and sticky_flags = 000 immediately, without waiting for a clock edge.
